// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the four-way mux arbiters: state codes, requester count and
// counter sizing.
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t GRANT = 2'd1;
  localparam state_t TURN  = 2'd2;

  // Bits needed to count from 0 up to and including max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick among four requests, starting just after 'last'.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Walk offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    valid = |req;
    idx   = last;
    cand  = last;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_bus_arbiter.sv
// Round-robin owner of a shared dual 4:1 selector: bounded hold per grant and a disabled
// turnaround gap between grants so the mux output never switches while enabled.
module mux4_bus_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD    = 8,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         sel,
  output logic               enb_n,
  output logic               busy
);

  localparam int unsigned HW = cnt_width(MAX_HOLD);
  localparam int unsigned TW = cnt_width(TURN_CYCLES);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TURN_LIM = TW'(TURN_CYCLES);

  state_t              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          sel_q, sel_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [TW-1:0]       turn_q, turn_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                enb_n_q, enb_n_d;
  logic                busy_q, busy_d;

  logic                pick_valid;
  logic [1:0]          pick_idx;
  logic [NUM_REQ-1:0]  others;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign others = req & ~gnt_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    gnt_d   = gnt_q;
    enb_n_d = enb_n_q;

    case (state_q)
      IDLE, TURN: begin
        if (state_q == TURN && turn_q != TURN_LIM) begin
          turn_d = turn_q + TW'(1);
        end else if (pick_valid) begin
          state_d = GRANT;
          last_d  = pick_idx;
          sel_d   = pick_idx;
          hold_d  = HW'(1);
          turn_d  = '0;
          gnt_d   = 4'b0001 << pick_idx;
          enb_n_d = 1'b0;
        end else begin
          state_d = IDLE;
          turn_d  = '0;
        end
      end
      GRANT: begin
        // A release coinciding with hold expiry takes the same path as preemption.
        if (!req[sel_q] || (hold_q == HOLD_LIM && |others)) begin
          state_d = TURN;
          turn_d  = TW'(1);
          gnt_d   = '0;
          enb_n_d = 1'b1;
        end else if (hold_q != HOLD_LIM) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        enb_n_d = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      hold_q  <= '0;
      turn_q  <= '0;
      gnt_q   <= '0;
      enb_n_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      gnt_q   <= gnt_d;
      enb_n_q <= enb_n_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign enb_n = enb_n_q;
  assign busy  = busy_q;

endmodule
